qlm_mac_acc: RTL and testbench

//  Streaming accumulator that consumes the 16-bit signed products of the 8x8 approximate log multiplier.

---
 rtl/qlm_pkg.sv | 32 +++
 rtl/qlm_sat_adder.sv | 31 +++
 rtl/qlm_mac_acc.sv | 118 +++++++++++
 tb/tb_qlm_mac_acc.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qlm_pkg.sv
// Shared types and helpers for the log-multiplier MAC accumulator.
package qlm_pkg;

  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } qlm_acc_state_e;

  // Returns {ovf, sum}: a+b clamped to the signed w-bit range, sign-extended to 64 bits.
  function automatic logic [64:0] sat_add(input longint a, input longint b, input int w);
    longint s;
    longint maxv;
    longint minv;
    logic   ovf;
    s    = a + b;
    maxv = (longint'(1) <<< (w - 1)) - 1;
    minv = -(longint'(1) <<< (w - 1));
    ovf  = 1'b0;
    if (s > maxv) begin
      s   = maxv;
      ovf = 1'b1;
    end else if (s < minv) begin
      s   = minv;
      ovf = 1'b1;
    end
    return {ovf, s};
  endfunction

endpackage

// File: rtl/qlm_sat_adder.sv
// ACC_W+1-bit adder that clamps the result back into the signed ACC_W range.
module qlm_sat_adder #(
  parameter int ACC_W = 24
) (
  input  logic [ACC_W-1:0] i_a,
  input  logic [ACC_W:0]   i_b,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_ovf
);

  logic [ACC_W:0] w_sum;
  logic           w_pos_ovf;
  logic           w_neg_ovf;

  // The operands fit in ACC_W+1 bits, so the top two bits disagreeing means out of range.
  assign w_sum     = {i_a[ACC_W-1], i_a} + i_b;
  assign w_pos_ovf = ~w_sum[ACC_W] &  w_sum[ACC_W-1];
  assign w_neg_ovf =  w_sum[ACC_W] & ~w_sum[ACC_W-1];

  always_comb begin
    o_sum = w_sum[ACC_W-1:0];
    if (w_pos_ovf) begin
      o_sum = {1'b0, {(ACC_W-1){1'b1}}};
    end else if (w_neg_ovf) begin
      o_sum = {1'b1, {(ACC_W-1){1'b0}}};
    end
  end

  assign o_ovf = w_pos_ovf | w_neg_ovf;

endmodule

// File: rtl/qlm_mac_acc.sv
// Saturating dot-product accumulator fed by the approximate log multiplier.
module qlm_mac_acc
  import qlm_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic [PROD_W-1:0] prod_i,
  input  logic              prod_neg_i,
  input  logic              prod_last_i,
  input  logic              prod_valid_i,
  output logic              prod_ready_o,
  output logic [ACC_W-1:0]  acc_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              ovf_o,
  output logic              len_err_o,
  output logic              acc_valid_o,
  input  logic              acc_ready_i
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  qlm_acc_state_e   r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_len_err;
  logic             r_acc_valid;
  logic             r_prod_ready;

  logic [ACC_W:0]   w_beat;
  logic [ACC_W-1:0] w_add_a;
  logic [ACC_W-1:0] w_sum;
  logic             w_ovf;
  logic             w_first;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Negative products are ones' complement; adding prod_neg_i turns them into two's complement.
  assign w_beat    = {{(ACC_W+1-PROD_W){prod_i[PROD_W-1]}}, prod_i}
                   + {{ACC_W{1'b0}}, prod_neg_i};
  assign w_first   = (r_state == IDLE);
  assign w_add_a   = w_first ? '0 : r_acc;
  assign w_cnt_nxt = w_first ? CNT_ONE : r_cnt + CNT_ONE;

  qlm_sat_adder #(
    .ACC_W (ACC_W)
  ) u_sat_adder (
    .i_a   (w_add_a),
    .i_b   (w_beat),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_ovf        <= 1'b0;
      r_len_err    <= 1'b0;
      r_acc_valid  <= 1'b0;
      r_prod_ready <= 1'b1;
    end else if (clr_i) begin
      r_state      <= IDLE;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_ovf        <= 1'b0;
      r_len_err    <= 1'b0;
      r_acc_valid  <= 1'b0;
      r_prod_ready <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE, ACC: begin
          if (prod_valid_i) begin
            r_acc <= w_sum;
            r_cnt <= w_cnt_nxt;
            r_ovf <= (w_first ? 1'b0 : r_ovf) | w_ovf;
            if (prod_last_i || (w_cnt_nxt == CNT_MAX)) begin
              r_state      <= HOLD;
              r_len_err    <= ~prod_last_i;
              r_acc_valid  <= 1'b1;
              r_prod_ready <= 1'b0;
            end else begin
              r_state   <= ACC;
              r_len_err <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (acc_ready_i) begin
            r_state      <= IDLE;
            r_ovf        <= 1'b0;
            r_len_err    <= 1'b0;
            r_acc_valid  <= 1'b0;
            r_prod_ready <= 1'b1;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_acc_valid  <= 1'b0;
          r_prod_ready <= 1'b1;
        end
      endcase
    end
  end

  assign prod_ready_o = r_prod_ready;
  assign acc_o        = r_acc;
  assign cnt_o        = r_cnt;
  assign ovf_o        = r_ovf;
  assign len_err_o    = r_len_err;
  assign acc_valid_o  = r_acc_valid;

endmodule

// File: tb/tb_qlm_mac_acc.sv
// Scoreboard bench for qlm_mac_acc, built with a narrow accumulator and counter so limits are reachable.
module tb_qlm_mac_acc;

  localparam int ACC_W = 17;
  localparam int CNT_W = 3;
  localparam int MAXV  = 65535;
  localparam int MINV  = -65536;
  localparam int LIMIT = 7;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              clr_i;
  logic [15:0]       prod_i;
  logic              prod_neg_i;
  logic              prod_last_i;
  logic              prod_valid_i;
  logic              prod_ready_o;
  logic [ACC_W-1:0]  acc_o;
  logic [CNT_W-1:0]  cnt_o;
  logic              ovf_o;
  logic              len_err_o;
  logic              acc_valid_o;
  logic              acc_ready_i;

  typedef struct {
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             lenErr;
  } expT;

  expT  sbQ[$];
  int   total = 0;
  int   bad   = 0;
  int   mAcc  = 0;
  int   mCnt  = 0;
  logic mOvf  = 1'b0;

  qlm_mac_acc #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clr_i        (clr_i),
    .prod_i       (prod_i),
    .prod_neg_i   (prod_neg_i),
    .prod_last_i  (prod_last_i),
    .prod_valid_i (prod_valid_i),
    .prod_ready_o (prod_ready_o),
    .acc_o        (acc_o),
    .cnt_o        (cnt_o),
    .ovf_o        (ovf_o),
    .len_err_o    (len_err_o),
    .acc_valid_o  (acc_valid_o),
    .acc_ready_i  (acc_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Drives one beat, waits for it to be accepted and advances the reference sum.
  task automatic applyStimulus(input logic [15:0] p, input logic neg, input logic last);
    bit  done;
    int  beat;
    expT e;
    done         = 1'b0;
    prod_i       = p;
    prod_neg_i   = neg;
    prod_last_i  = last;
    prod_valid_i = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk_i);
      if (prod_ready_o) done = 1'b1;
    end
    @(posedge clk_i);
    #1;
    prod_valid_i = 1'b0;
    if (!done) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
    end else begin
      beat = int'($signed(p)) + int'(neg);
      if (mCnt == 0) begin
        mAcc = 0;
        mOvf = 1'b0;
      end
      mAcc = mAcc + beat;
      if (mAcc > MAXV) begin
        mAcc = MAXV;
        mOvf = 1'b1;
      end else if (mAcc < MINV) begin
        mAcc = MINV;
        mOvf = 1'b1;
      end
      mCnt++;
      if (last || mCnt == LIMIT) begin
        e.acc    = ACC_W'(mAcc);
        e.cnt    = CNT_W'(mCnt);
        e.ovf    = mOvf;
        e.lenErr = ~last;
        sbQ.push_back(e);
        mCnt = 0;
      end
    end
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 30 && sbQ.size() != 0; i++) begin
      @(posedge clk_i);
      #2;
    end
    checkOutput(tag, 32'(sbQ.size()), 32'd0);
  endtask

  // Compares each result against the oldest expectation when the output handshake happens.
  always @(negedge clk_i) begin : monitor
    expT e;
    if (rst_ni && !clr_i && acc_valid_o && acc_ready_i) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("res_acc", 32'(acc_o), 32'(e.acc));
        checkOutput("res_cnt", 32'(cnt_o), 32'(e.cnt));
        checkOutput("res_ovf", 32'(ovf_o), 32'(e.ovf));
        checkOutput("res_len_err", 32'(len_err_o), 32'(e.lenErr));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=running want=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_ni       = 1'b0;
    clr_i        = 1'b0;
    prod_i       = '0;
    prod_neg_i   = 1'b0;
    prod_last_i  = 1'b0;
    prod_valid_i = 1'b0;
    acc_ready_i  = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    checkOutput("rst_acc", 32'(acc_o), 32'd0);
    checkOutput("rst_cnt", 32'(cnt_o), 32'd0);
    checkOutput("rst_ovf", 32'(ovf_o), 32'd0);
    checkOutput("rst_len_err", 32'(len_err_o), 32'd0);
    checkOutput("rst_valid", 32'(acc_valid_o), 32'd0);
    checkOutput("rst_ready", 32'(prod_ready_o), 32'd1);

    // Basic vector and latency.
    applyStimulus(16'd100, 1'b0, 1'b0);
    checkOutput("valid_early", 32'(acc_valid_o), 32'd0);
    applyStimulus(16'd200, 1'b0, 1'b0);
    applyStimulus(16'd300, 1'b0, 1'b1);
    checkOutput("valid_latency", 32'(acc_valid_o), 32'd1);
    waitDrain("drain_basic");

    // Ones' complement correction and zero products.
    applyStimulus(16'hFFF5, 1'b1, 1'b0);
    applyStimulus(16'h0014, 1'b0, 1'b1);
    applyStimulus(16'h0000, 1'b0, 1'b0);
    applyStimulus(16'h0007, 1'b0, 1'b1);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    waitDrain("drain_onescomp");

    // Positive and negative saturation, no lock after saturating.
    repeat (3) applyStimulus(16'h7FFF, 1'b0, 1'b0);
    applyStimulus(16'h7FFF, 1'b0, 1'b1);
    applyStimulus(16'h0005, 1'b0, 1'b1);
    repeat (3) applyStimulus(16'h7FFF, 1'b0, 1'b0);
    applyStimulus(16'h8000, 1'b0, 1'b1);
    repeat (2) applyStimulus(16'h8000, 1'b0, 1'b0);
    applyStimulus(16'h8000, 1'b0, 1'b1);
    waitDrain("drain_sat");

    // Backpressure: result held, extra beat refused.
    acc_ready_i = 1'b0;
    applyStimulus(16'd1, 1'b0, 1'b0);
    applyStimulus(16'd2, 1'b0, 1'b1);
    prod_i       = 16'd99;
    prod_neg_i   = 1'b0;
    prod_last_i  = 1'b1;
    prod_valid_i = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      checkOutput("bp_valid", 32'(acc_valid_o), 32'd1);
      checkOutput("bp_acc", 32'(acc_o), 32'd3);
      checkOutput("bp_cnt", 32'(cnt_o), 32'd2);
      checkOutput("bp_ready", 32'(prod_ready_o), 32'd0);
    end
    @(posedge clk_i);
    #1;
    prod_valid_i = 1'b0;
    acc_ready_i  = 1'b1;
    @(posedge clk_i);
    #1;
    checkOutput("idle_valid", 32'(acc_valid_o), 32'd0);
    checkOutput("idle_ready", 32'(prod_ready_o), 32'd1);
    checkOutput("idle_ovf", 32'(ovf_o), 32'd0);
    waitDrain("drain_bp");

    // Length limit without last.
    repeat (7) applyStimulus(16'd1, 1'b0, 1'b0);
    waitDrain("drain_len");

    // Abort mid-vector with a beat in the same cycle.
    applyStimulus(16'd10, 1'b0, 1'b0);
    applyStimulus(16'd10, 1'b0, 1'b0);
    prod_i       = 16'd50;
    prod_last_i  = 1'b1;
    prod_valid_i = 1'b1;
    clr_i        = 1'b1;
    @(posedge clk_i);
    #1;
    clr_i        = 1'b0;
    prod_valid_i = 1'b0;
    mCnt         = 0;
    checkOutput("clr_acc", 32'(acc_o), 32'd0);
    checkOutput("clr_cnt", 32'(cnt_o), 32'd0);
    checkOutput("clr_valid", 32'(acc_valid_o), 32'd0);
    checkOutput("clr_ready", 32'(prod_ready_o), 32'd1);
    applyStimulus(16'd4, 1'b0, 1'b1);
    waitDrain("drain_clr");

    // Abort discards a held result.
    acc_ready_i = 1'b0;
    applyStimulus(16'd9, 1'b0, 1'b1);
    checkOutput("hold_valid", 32'(acc_valid_o), 32'd1);
    clr_i = 1'b1;
    @(posedge clk_i);
    #1;
    clr_i = 1'b0;
    void'(sbQ.pop_back());
    checkOutput("clr_hold_valid", 32'(acc_valid_o), 32'd0);
    checkOutput("clr_hold_acc", 32'(acc_o), 32'd0);
    acc_ready_i = 1'b1;

    // Asynchronous reset mid-vector.
    applyStimulus(16'd7, 1'b0, 1'b0);
    applyStimulus(16'd7, 1'b0, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("arst_acc", 32'(acc_o), 32'd0);
    checkOutput("arst_cnt", 32'(cnt_o), 32'd0);
    checkOutput("arst_valid", 32'(acc_valid_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    mCnt   = 0;
    @(posedge clk_i);
    #1;
    checkOutput("arst_ready", 32'(prod_ready_o), 32'd1);
    applyStimulus(16'd3, 1'b0, 1'b1);
    waitDrain("drain_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
